fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program-counter and prefetch sequencer that sits directly upstream of the program memory/cache stage. It owns the PC and drives the word Address into the program memory. It fetches the lookahead word (PC+LOOKAHEAD) from the slow external program store over a req/ack handshake and presents it on plus32 so the inactive switching cache can be refilled. It also handles branch redirects and pipeline stalls.

Parameters:
ADDR_W, 10, word-address width of PC, Address, Mem_Addr
LOOKAHEAD, 8, distance in words between the issued Address and the prefetched word (one switching-cache line)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
Stall  input  1  hold the PC; no advance while high
Branch_En  input  1  redirect request, sampled every cycle
Branch_Target  input  ADDR_W  new PC when Branch_En=1
Mem_Ack  input  1  external store has Mem_Data valid for the outstanding request
Mem_Data  input  32  external store read data
Mem_Req  output  1  request to external store; level, held until Mem_Ack
Mem_Addr  output  ADDR_W  external store word address
Address  output  ADDR_W  word address into program memory
plus32  output  32  prefetched word at Address+LOOKAHEAD
Fetch_Valid  output  1  one-cycle pulse: new Address/plus32 pair issued

Behaviour:
- Reset (async, Reset=0):
  - PC=RESET_PC, state=REQ, Discard=0.
  - Address=RESET_PC, plus32=0, Fetch_Valid=0, Mem_Req=0, Mem_Addr=0.
  - Mem_Req drops immediately even mid-transaction; no response is awaited after release.
- All outputs are registered. States: REQ, WAIT, ISSUE, NEXT.
- REQ: at the edge, Mem_Req<=1, Mem_Addr<=(PC+LOOKAHEAD) mod 2^ADDR_W, then -> WAIT.
- WAIT: Mem_Req and Mem_Addr are held stable until Mem_Ack=1. At the Ack edge:
  - Mem_Req<=0.
  - If Discard=0: plus32<=Mem_Data, -> ISSUE.
  - If Discard=1: data dropped, Discard<=0, -> REQ.
- ISSUE: at the edge, Address<=PC, Fetch_Valid<=1, -> NEXT.
- NEXT: at every edge, Fetch_Valid<=0.
  - Stall=1: remain in NEXT; Address and plus32 held.
  - Stall=0: PC<=(PC+1) mod 2^ADDR_W, -> REQ.
- Throughput: minimum 4 cycles per instruction with Mem_Ack high in the first WAIT cycle.
  - From reset release with Mem_Ack tied high: edge1 Mem_Req=1, Mem_Addr=8; edge2 plus32 loaded; edge3 Address=0, Fetch_Valid=1; edge4 PC=1, Fetch_Valid=0.
- Branch_En (highest priority, any state):
  - PC<=Branch_Target, Fetch_Valid<=0; Address is not changed until the next ISSUE.
  - In REQ/ISSUE/NEXT: -> REQ next cycle, Mem_Req<=0.
  - In WAIT without Ack: Discard<=1, stay in WAIT. The request is never withdrawn; Mem_Req stays high until Ack.
  - In WAIT with Ack in the same cycle: data dropped, Discard stays 0, -> REQ with the new PC.
  - Branch while Discard=1: only PC updated.
  - Branch and Stall together: the branch wins.
- Mem_Ack outside WAIT is ignored; plus32 is unchanged.
- Wrap-around: PC 2^ADDR_W-1 increments to 0. Mem_Addr wraps modulo 2^ADDR_W (PC=1020 -> Mem_Addr=4).
- Invariant: while Fetch_Valid=1, plus32 = store[(Address+LOOKAHEAD) mod 2^ADDR_W].

Test Plan:
- Reset release, Mem_Ack=1, store[i]=i+0x100 -> Fetch_Valid pulses every 4 cycles. Address sequence 0,1,2,…; plus32 = 0x108,0x109,0x10A,…; Mem_Addr = 8,9,10,….
- Mem_Ack delayed 5 cycles on the PC=3 request -> Mem_Req high for all 5 WAIT cycles, Mem_Addr=11 stable, no Fetch_Valid until after Ack; then Address=3, plus32=store[11].
- Stall=1 for 6 cycles right after the Address=2 pulse -> Fetch_Valid high for one cycle only, Address=2 held, no Mem_Req; after release the next request has Mem_Addr=11.
- Branch_En with Branch_Target=0x100 while in WAIT for Mem_Addr=13 -> Mem_Req stays high until Ack, that data is discarded (plus32 unchanged). Next request Mem_Addr=0x108, next issue Address=0x100. Repeat with Branch_En coincident with Ack -> same result.
- Branch to 1022 -> requests at Mem_Addr 6,7,8; Address sequence 1022,1023,0.
- Reset asserted during WAIT with Mem_Req=1 -> Mem_Req and all outputs clear asynchronously. After release, a late Mem_Ack is ignored and the sequence restarts at Address=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// External program-store read channel: level request held until a one-cycle ack with data.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              Mem_Req;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ack;
  logic [31:0]       Mem_Data;

  modport master (output Mem_Req, Mem_Addr, input Mem_Ack, Mem_Data);
  modport slave  (input Mem_Req, Mem_Addr, output Mem_Ack, Mem_Data);
endinterface

// File: rtl/fetch_sequencer.sv
// PC / prefetch sequencer: fetches the word LOOKAHEAD ahead of the issued Address from the
// slow store, then issues the Address/plus32 pair; handles branches and stalls.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       LOOKAHEAD = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                Branch_En,
  input  logic [ADDR_W-1:0]   Branch_Target,
  fetch_sequencer_if.master   mem,
  output logic [ADDR_W-1:0]   Address,
  output logic [31:0]         plus32,
  output logic                Fetch_Valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_discard;
  logic [ADDR_W-1:0] r_address;
  logic [31:0]       r_plus32;
  logic              r_fetch_valid;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;

  logic [ADDR_W-1:0] w_prefetch_addr;
  logic [ADDR_W-1:0] w_pc_inc;

  // Both wrap naturally modulo 2^ADDR_W.
  assign w_prefetch_addr = r_pc + ADDR_W'(LOOKAHEAD);
  assign w_pc_inc        = r_pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_discard     <= 1'b0;
      r_address     <= RESET_PC;
      r_plus32      <= '0;
      r_fetch_valid <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
    end else if (Branch_En) begin
      // A request already on the wire is never withdrawn; its data is dropped on arrival.
      r_pc          <= Branch_Target;
      r_fetch_valid <= 1'b0;
      if (r_state == S_WAIT) begin
        if (mem.Mem_Ack) begin
          r_mem_req <= 1'b0;
          r_discard <= 1'b0;
          r_state   <= S_REQ;
        end else begin
          r_discard <= 1'b1;
        end
      end else begin
        r_mem_req <= 1'b0;
        r_state   <= S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= w_prefetch_addr;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (mem.Mem_Ack) begin
            r_mem_req <= 1'b0;
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_plus32 <= mem.Mem_Data;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_address     <= r_pc;
          r_fetch_valid <= 1'b1;
          r_state       <= S_NEXT;
        end
        S_NEXT: begin
          r_fetch_valid <= 1'b0;
          if (!Stall) begin
            r_pc    <= w_pc_inc;
            r_state <= S_REQ;
          end
        end
      endcase
    end
  end

  assign Address      = r_address;
  assign plus32       = r_plus32;
  assign Fetch_Valid  = r_fetch_valid;
  assign mem.Mem_Req  = r_mem_req;
  assign mem.Mem_Addr = r_mem_addr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a transaction-level PC/store model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LA     = 8;
  localparam int unsigned BUDGET = 40;

  logic              clk           = 1'b0;
  logic              Reset         = 1'b0;
  logic              Stall         = 1'b0;
  logic              Branch_En     = 1'b0;
  logic [ADDR_W-1:0] Branch_Target = '0;
  logic              ack           = 1'b1;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       plus32;
  logic              Fetch_Valid;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] store_word(input logic [ADDR_W-1:0] a);
    return 32'h100 + 32'(a);
  endfunction

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) mem_if ();
  assign mem_if.Mem_Ack  = ack;
  assign mem_if.Mem_Data = store_word(mem_if.Mem_Addr);

  fetch_sequencer #(.ADDR_W(ADDR_W), .LOOKAHEAD(LA), .RESET_PC('0)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .Branch_En    (Branch_En),
    .Branch_Target(Branch_Target),
    .mem          (mem_if),
    .Address      (Address),
    .plus32       (plus32),
    .Fetch_Valid  (Fetch_Valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the next issued address is the last issue + 1, unless a branch was taken since.
  logic [ADDR_W-1:0] exp_pc;
  logic              ack_edge;
  logic              prev_fv, prev_req;
  logic [ADDR_W-1:0] prev_addr, prev_mem_addr;

  always @(posedge clk) begin
    if (Reset) begin
      ack_edge = ack;
      if (Branch_En) exp_pc = Branch_Target;
    end
  end

  always @(negedge clk) begin
    if (!Reset) begin
      exp_pc        = '0;
      prev_fv       = 1'b0;
      prev_req      = 1'b0;
      prev_addr     = '0;
      prev_mem_addr = '0;
    end else begin
      if (prev_fv) chk("fv_pulse_width", 32'(Fetch_Valid), 0);
      if (Fetch_Valid) begin
        chk("issue_addr", 32'(Address), 32'(exp_pc));
        chk("issue_plus32", plus32, store_word(ADDR_W'(Address + LA)));
        exp_pc = ADDR_W'(exp_pc + 1);
      end else begin
        chk("addr_hold", 32'(Address), 32'(prev_addr));
      end
      if (mem_if.Mem_Req && !prev_req)
        chk("req_addr", 32'(mem_if.Mem_Addr), 32'(ADDR_W'(exp_pc + LA)));
      if (mem_if.Mem_Req && prev_req)
        chk("req_addr_stable", 32'(mem_if.Mem_Addr), 32'(prev_mem_addr));
      if (!mem_if.Mem_Req && prev_req)
        chk("req_release_needs_ack", 32'(ack_edge), 1);
      prev_fv       = Fetch_Valid;
      prev_req      = mem_if.Mem_Req;
      prev_addr     = Address;
      prev_mem_addr = mem_if.Mem_Addr;
    end
  end

  task automatic wait_fv(input string name, output logic [ADDR_W-1:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Fetch_Valid && n < BUDGET);
    chk({name, "_fv_arrived"}, 32'(Fetch_Valid), 1);
    a = Address;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_if.Mem_Req && n < BUDGET);
    chk({name, "_req_arrived"}, 32'(mem_if.Mem_Req), 1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;

    // Reset values
    #12;
    chk("rst_address", 32'(Address), 0);
    chk("rst_plus32", plus32, 0);
    chk("rst_fv", 32'(Fetch_Valid), 0);
    chk("rst_req", 32'(mem_if.Mem_Req), 0);
    chk("rst_mem_addr", 32'(mem_if.Mem_Addr), 0);

    // Release with ack tied high: 4-cycle cadence
    @(negedge clk); Reset = 1'b1;
    @(negedge clk);
    chk("e1_req", 32'(mem_if.Mem_Req), 1);
    chk("e1_mem_addr", 32'(mem_if.Mem_Addr), 8);
    @(negedge clk);
    chk("e2_plus32", plus32, 32'h108);
    chk("e2_fv", 32'(Fetch_Valid), 0);
    @(negedge clk);
    chk("e3_fv", 32'(Fetch_Valid), 1);
    chk("e3_address", 32'(Address), 0);
    @(negedge clk);
    chk("e4_fv", 32'(Fetch_Valid), 0);

    wait_fv("seq1", a);
    chk("seq1_addr", 32'(a), 1);
    chk("seq1_plus32", plus32, 32'h109);
    wait_fv("seq2", a);
    chk("seq2_addr", 32'(a), 2);

    // Stall 6 cycles right after the Address=2 pulse; next request made to wait on ack
    Stall = 1'b1;
    ack   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_fv", 32'(Fetch_Valid), 0);
      chk("stall_req", 32'(mem_if.Mem_Req), 0);
      chk("stall_address", 32'(Address), 2);
    end
    Stall = 1'b0;

    // Delayed ack on the PC=3 request
    wait_req("req11");
    for (int i = 0; i < 5; i++) begin
      chk("dly_req", 32'(mem_if.Mem_Req), 1);
      chk("dly_mem_addr", 32'(mem_if.Mem_Addr), 11);
      chk("dly_fv", 32'(Fetch_Valid), 0);
      if (i < 4) @(negedge clk);
    end
    ack = 1'b1;
    wait_fv("dly", a);
    chk("dly_addr", 32'(a), 3);
    chk("dly_plus32", plus32, 32'h10B);

    // Branch while waiting for Mem_Addr=13: data discarded, request held to ack
    wait_fv("seq4", a);
    chk("seq4_addr", 32'(a), 4);
    ack = 1'b0;
    wait_req("req13");
    chk("br_req_addr", 32'(mem_if.Mem_Addr), 13);
    Branch_En     = 1'b1;
    Branch_Target = 10'h100;
    @(negedge clk);
    Branch_En = 1'b0;
    chk("br_req_held", 32'(mem_if.Mem_Req), 1);
    chk("br_mem_addr_held", 32'(mem_if.Mem_Addr), 13);
    @(negedge clk);
    chk("br_req_held2", 32'(mem_if.Mem_Req), 1);
    ack = 1'b1;
    @(negedge clk);
    chk("br_req_drop", 32'(mem_if.Mem_Req), 0);
    chk("br_plus32_kept", plus32, 32'h10C);
    chk("br_address_kept", 32'(Address), 4);
    chk("br_fv", 32'(Fetch_Valid), 0);
    wait_req("req108");
    chk("br_new_mem_addr", 32'(mem_if.Mem_Addr), 32'h108);
    wait_fv("br", a);
    chk("br_issue_addr", 32'(a), 32'h100);
    chk("br_issue_plus32", plus32, 32'h208);

    // Branch coincident with ack
    ack = 1'b0;
    wait_req("req109");
    chk("bra_req_addr", 32'(mem_if.Mem_Addr), 32'h109);
    Branch_En     = 1'b1;
    Branch_Target = 10'h100;
    ack           = 1'b1;
    @(negedge clk);
    Branch_En = 1'b0;
    chk("bra_req_drop", 32'(mem_if.Mem_Req), 0);
    chk("bra_plus32_kept", plus32, 32'h208);
    chk("bra_fv", 32'(Fetch_Valid), 0);
    wait_req("bra_req108");
    chk("bra_new_mem_addr", 32'(mem_if.Mem_Addr), 32'h108);
    wait_fv("bra", a);
    chk("bra_issue_addr", 32'(a), 32'h100);

    // Branch with Stall in NEXT (branch wins) to 1022, then wrap
    Stall         = 1'b1;
    Branch_En     = 1'b1;
    Branch_Target = 10'd1022;
    @(negedge clk);
    Stall     = 1'b0;
    Branch_En = 1'b0;
    chk("bs_fv", 32'(Fetch_Valid), 0);
    chk("bs_address_kept", 32'(Address), 32'h100);
    wait_req("wrap_r0");
    chk("wrap_mem_addr0", 32'(mem_if.Mem_Addr), 6);
    wait_fv("wrap0", a);
    chk("wrap_addr0", 32'(a), 1022);
    chk("wrap_plus0", plus32, 32'h106);
    wait_req("wrap_r1");
    chk("wrap_mem_addr1", 32'(mem_if.Mem_Addr), 7);
    wait_fv("wrap1", a);
    chk("wrap_addr1", 32'(a), 1023);
    wait_req("wrap_r2");
    chk("wrap_mem_addr2", 32'(mem_if.Mem_Addr), 8);
    wait_fv("wrap2", a);
    chk("wrap_addr2", 32'(a), 0);
    chk("wrap_plus2", plus32, 32'h108);

    // Asynchronous reset mid-WAIT, then a late ack after release
    ack = 1'b0;
    wait_req("req9");
    chk("ar_mem_addr_before", 32'(mem_if.Mem_Addr), 9);
    #3 Reset = 1'b0;
    #1;
    chk("ar_req", 32'(mem_if.Mem_Req), 0);
    chk("ar_mem_addr", 32'(mem_if.Mem_Addr), 0);
    chk("ar_plus32", plus32, 0);
    chk("ar_fv", 32'(Fetch_Valid), 0);
    chk("ar_address", 32'(Address), 0);
    @(negedge clk);
    @(negedge clk);
    ack   = 1'b1;
    Reset = 1'b1;
    @(negedge clk);
    chk("late_req", 32'(mem_if.Mem_Req), 1);
    chk("late_mem_addr", 32'(mem_if.Mem_Addr), 8);
    chk("late_plus32_ignored", plus32, 0);
    ack = 1'b0;
    @(negedge clk);
    chk("late_req_held", 32'(mem_if.Mem_Req), 1);
    chk("late_fv", 32'(Fetch_Valid), 0);
    ack = 1'b1;
    wait_fv("restart", a);
    chk("restart_addr", 32'(a), 0);
    chk("restart_plus32", plus32, 32'h108);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
